// File: rtl/mem_access_unit.sv
// Data-memory sequencer for the register bank: LOAD/STORE/PUSH/POP over a
// single-port synchronous RAM with bounds-checked addressing and SP update.
module mem_access_unit #(
  parameter int REGISTER_LENGTH = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_DEPTH       = 8192,
  parameter int READ_LATENCY    = 1,
  parameter int STACK_LIMIT     = 6144,
  parameter int USER_STACK      = 8191
) (
  input  logic                       fast_clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic [REGISTER_LENGTH-1:0] store_data,
  input  logic [REGISTER_LENGTH-1:0] current_SP,
  input  logic [REGISTER_LENGTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [REGISTER_LENGTH-1:0] mem_wdata,
  output logic                       mem_we,
  output logic                       mem_re,
  output logic [REGISTER_LENGTH-1:0] data_from_memory,
  output logic [REGISTER_LENGTH-1:0] new_SP,
  output logic                       busy,
  output logic                       done,
  output logic                       fault
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_PUSH  = 2'd2;
  localparam logic [1:0] OP_POP   = 2'd3;

  localparam logic [2:0]                 RL_LAST  = 3'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0]      DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [REGISTER_LENGTH-1:0] DEPTH_R  = REGISTER_LENGTH'(MEM_DEPTH);
  localparam logic [REGISTER_LENGTH-1:0] LIMIT_R  = REGISTER_LENGTH'(STACK_LIMIT);
  localparam logic [REGISTER_LENGTH-1:0] USTACK_R = REGISTER_LENGTH'(USER_STACK);
  localparam logic [REGISTER_LENGTH-1:0] ONE_R    = REGISTER_LENGTH'(1);

  state_t state, state_d;

  logic [1:0]                 op_q, op_d;
  logic [REGISTER_LENGTH-1:0] spq, spq_d;
  logic                       flt_q, flt_d;
  logic [2:0]                 cnt, cnt_d;

  logic [ADDR_WIDTH-1:0]      addr_d;
  logic [REGISTER_LENGTH-1:0] wdata_d, dfm_d, sp_d, sp_fin;
  logic                       we_d, re_d, busy_d, done_d, fault_d;

  logic [ADDR_WIDTH-1:0]      ea;
  logic                       flt;

  // Effective address and refusal are decided from the live inputs in the
  // accept cycle so the strobe can be registered straight into ISSUE.
  always_comb begin
    ea  = address;
    flt = 1'b0;
    unique case (op)
      OP_LOAD, OP_STORE: begin
        ea  = address;
        flt = (address >= DEPTH_A);
      end
      OP_PUSH: begin
        ea  = ADDR_WIDTH'(current_SP);
        flt = (current_SP < LIMIT_R) || (current_SP >= DEPTH_R);
      end
      OP_POP: begin
        ea  = ADDR_WIDTH'(current_SP + ONE_R);
        flt = (current_SP >= USTACK_R);
      end
    endcase
  end

  always_comb begin
    sp_fin = spq;
    if (!flt_q) begin
      if (op_q == OP_PUSH)     sp_fin = spq - ONE_R;
      else if (op_q == OP_POP) sp_fin = spq + ONE_R;
    end
  end

  always_ff @(posedge fast_clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: state_d = (!flt_q && (op_q == OP_LOAD || op_q == OP_POP)) ? S_WAIT : S_DONE;
      S_WAIT:  if (cnt == RL_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    spq_d   = spq;
    flt_d   = flt_q;
    cnt_d   = cnt;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    dfm_d   = data_from_memory;
    sp_d    = new_SP;
    we_d    = 1'b0;
    re_d    = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;
    fault_d = fault;
    unique case (state)
      S_IDLE: begin
        sp_d = current_SP;
        if (start) begin
          op_d    = op;
          spq_d   = current_SP;
          flt_d   = flt;
          busy_d  = 1'b1;
          fault_d = 1'b0;
          if (!flt) begin
            addr_d = ea;
            if (op == OP_STORE || op == OP_PUSH) begin
              we_d    = 1'b1;
              wdata_d = store_data;
            end else begin
              re_d = 1'b1;
            end
          end
        end
      end
      S_ISSUE: begin
        if (state_d == S_WAIT) begin
          cnt_d = 3'd1;
        end else begin
          done_d  = 1'b1;
          fault_d = flt_q;
          sp_d    = sp_fin;
        end
      end
      S_WAIT: begin
        if (cnt == RL_LAST) begin
          dfm_d   = mem_rdata;
          done_d  = 1'b1;
          fault_d = 1'b0;
          sp_d    = sp_fin;
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        fault_d = 1'b0;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge fast_clock) begin
    if (!reset) begin
      op_q             <= OP_LOAD;
      spq              <= '0;
      flt_q            <= 1'b0;
      cnt              <= 3'd0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      mem_we           <= 1'b0;
      mem_re           <= 1'b0;
      data_from_memory <= '0;
      new_SP           <= USTACK_R;
      busy             <= 1'b0;
      done             <= 1'b0;
      fault            <= 1'b0;
    end else begin
      op_q             <= op_d;
      spq              <= spq_d;
      flt_q            <= flt_d;
      cnt              <= cnt_d;
      mem_addr         <= addr_d;
      mem_wdata        <= wdata_d;
      mem_we           <= we_d;
      mem_re           <= re_d;
      data_from_memory <= dfm_d;
      new_SP           <= sp_d;
      busy             <= busy_d;
      done             <= done_d;
      fault            <= fault_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance at READ_LATENCY=1 with a
// 1-cycle RAM model, a second at READ_LATENCY=3 for the latency sweep.
module tb_mem_access_unit;

  logic        fast_clock = 1'b0;
  logic        reset, start, start3;
  logic [1:0]  op;
  logic [31:0] address, store_data, current_SP;
  logic [31:0] mem_rdata, mem_addr, mem_wdata, data_from_memory, new_SP;
  logic        mem_we, mem_re, busy, done, fault;
  logic [31:0] mem_rdata3, mem_addr3, mem_wdata3, dfm3, new_SP3;
  logic        mem_we3, mem_re3, busy3, done3, fault3;

  logic [31:0] mem [0:8191];
  logic [31:0] rp0, rp1, rp2;

  int checks = 0;
  int failures = 0;

  always #5 fast_clock = ~fast_clock;

  mem_access_unit u_dut (
    .fast_clock(fast_clock), .reset(reset), .start(start), .op(op),
    .address(address), .store_data(store_data), .current_SP(current_SP),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .data_from_memory(data_from_memory),
    .new_SP(new_SP), .busy(busy), .done(done), .fault(fault)
  );

  mem_access_unit #(.READ_LATENCY(3)) u_dut3 (
    .fast_clock(fast_clock), .reset(reset), .start(start3), .op(op),
    .address(address), .store_data(store_data), .current_SP(current_SP),
    .mem_rdata(mem_rdata3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_we(mem_we3), .mem_re(mem_re3), .data_from_memory(dfm3),
    .new_SP(new_SP3), .busy(busy3), .done(done3), .fault(fault3)
  );

  // Read data is poisoned unless a read was issued, so mistimed sampling shows up.
  always @(posedge fast_clock) begin
    if (mem_we) mem[mem_addr[12:0]] <= mem_wdata;
    mem_rdata <= mem_re ? mem[mem_addr[12:0]] : 32'hBAD0_BAD0;
    rp0 <= mem_re3 ? mem[mem_addr3[12:0]] : 32'hBAD0_BAD0;
    rp1 <= rp0;
    rp2 <= rp1;
  end
  assign mem_rdata3 = rp2;

  task automatic tick();
    @(posedge fast_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fault_case(input string tag, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] sp);
    current_SP = sp; op = o; address = a; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_c1_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_c1_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_c1_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_fault"}, 32'(fault), 32'd1);
    chk({tag, "_sp"}, new_SP, sp);
    chk({tag, "_dfm"}, data_from_memory, 32'h11);
    chk({tag, "_c2_strobe"}, 32'(mem_we | mem_re), 32'd0);
    tick();
    chk({tag, "_idle_fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
    reset = 1'b0; start = 1'b0; start3 = 1'b0; op = 2'd0;
    address = 32'd0; store_data = 32'd0; current_SP = 32'd5000;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_re", 32'(mem_re), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_dfm", data_from_memory, 32'd0);
    chk("rst_sp", new_SP, 32'd8191);
    reset = 1'b1;
    tick();
    chk("idle_sp_track", new_SP, 32'd5000);

    // STORE 100 <- DEADBEEF
    op = 2'd1; address = 32'd100; store_data = 32'hDEADBEEF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_re", 32'(mem_re), 32'd0);
    chk("st_addr", mem_addr, 32'd100);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_busy", 32'(busy), 32'd1);
    chk("st_c1_done", 32'(done), 32'd0);
    tick();
    chk("st_done", 32'(done), 32'd1);
    chk("st_fault", 32'(fault), 32'd0);
    chk("st_sp", new_SP, 32'd5000);
    chk("st_c2_we", 32'(mem_we), 32'd0);
    tick();
    chk("st_idle_busy", 32'(busy), 32'd0);
    chk("st_idle_done", 32'(done), 32'd0);

    // LOAD 100, latency 1
    op = 2'd0; address = 32'd100; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ld_re", 32'(mem_re), 32'd1);
    chk("ld_we", 32'(mem_we), 32'd0);
    chk("ld_addr", mem_addr, 32'd100);
    tick();
    chk("ld_c2_done", 32'(done), 32'd0);
    chk("ld_c2_re", 32'(mem_re), 32'd0);
    chk("ld_c2_busy", 32'(busy), 32'd1);
    chk("ld_c2_addr", mem_addr, 32'd100);
    tick();
    chk("ld_done", 32'(done), 32'd1);
    chk("ld_dfm", data_from_memory, 32'hDEADBEEF);
    chk("ld_fault", 32'(fault), 32'd0);
    tick();

    // LOAD 100 on the latency-3 instance: done in cycle 5
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk("ld3_re", 32'(mem_re3), 32'd1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("ld3_early_done", 32'(done3), 32'd0);
      chk("ld3_busy", 32'(busy3), 32'd1);
    end
    tick();
    chk("ld3_done", 32'(done3), 32'd1);
    chk("ld3_dfm", dfm3, 32'hDEADBEEF);
    tick();

    // PUSH 0x11 at SP=8191
    current_SP = 32'd8191; op = 2'd2; store_data = 32'h11; start = 1'b1;
    tick();
    start = 1'b0;
    chk("push_we", 32'(mem_we), 32'd1);
    chk("push_addr", mem_addr, 32'd8191);
    chk("push_wdata", mem_wdata, 32'h11);
    tick();
    chk("push_done", 32'(done), 32'd1);
    chk("push_sp", new_SP, 32'd8190);
    tick();

    // POP at SP=8190 reads mem[8191]
    current_SP = 32'd8190; op = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("pop_re", 32'(mem_re), 32'd1);
    chk("pop_addr", mem_addr, 32'd8191);
    tick();
    chk("pop_c2_done", 32'(done), 32'd0);
    tick();
    chk("pop_done", 32'(done), 32'd1);
    chk("pop_dfm", data_from_memory, 32'h11);
    chk("pop_sp", new_SP, 32'd8191);
    tick();

    fault_case("f_pop", 2'd3, 32'd0, 32'd8191);
    fault_case("f_push", 2'd2, 32'd0, 32'd6143);
    fault_case("f_load", 2'd0, 32'd8192, 32'd5000);

    // Reset while a LOAD sits in WAIT
    op = 2'd0; address = 32'd100; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_re", 32'(mem_re), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_sp", new_SP, 32'd8191);
    chk("mrst_dfm", data_from_memory, 32'd0);
    reset = 1'b1;
    tick();
    chk("mrst_c1_strobe", 32'(mem_we | mem_re), 32'd0);
    op = 2'd1; address = 32'd300; store_data = 32'h77; start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_we", 32'(mem_we), 32'd1);
    chk("post_rst_addr", mem_addr, 32'd300);
    tick();
    chk("post_rst_done", 32'(done), 32'd1);
    tick();

    // start held high: STORE accepted every 3rd cycle
    op = 2'd1; address = 32'd200; store_data = 32'h55; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("hold_busy", 32'(busy), 32'((c % 3) != 0));
      chk("hold_we", 32'(mem_we), 32'((c % 3) == 1));
      chk("hold_done", 32'(done), 32'((c % 3) == 2));
      chk("hold_overlap", 32'(mem_we & mem_re), 32'd0);
    end
    start = 1'b0;
    tick();
    chk("hold_end_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
